program_load_sequencer: RTL and testbench

- Owns the single program-memory port and decides, each cycle, whether the UART loader or the fetch stage drives it.
- Sequences the boot flow: idle, load program words from the UART, drain, run until fetch reports completion, then allow a reload.
- Replaces the ad-hoc address mux and run-flag logic at CPU top level; sits between uart_wrapper, program_memory and fetch_stage.

---
 rtl/program_load_sequencer.sv | 153 +++++++++++++++
 tb/tb_program_load_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_load_sequencer.sv
// Program-memory port owner and boot sequencer: UART load, arm, run, done, reload.
// Optional RUN watchdog enabled by defining PROGRAM_LOAD_WATCHDOG_EN (adds wdog_fired).
module program_load_sequencer #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MEM_BYTES    = 4096,
  parameter logic [15:0] START_MARKER = 16'h1111,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned WDOG_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_valid,
  input  logic [31:0]       uart_data,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              run_finished,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              run_flag,
  output logic [CNT_W-1:0]  load_count,
  output logic [2:0]        state,
`ifdef PROGRAM_LOAD_WATCHDOG_EN
  output logic              wdog_fired,
`endif
  output logic              load_error
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StArm  = 3'd2,
    StRun  = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] MemLimit = ADDR_W'(MEM_BYTES);

  state_e            state_q, state_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic [CNT_W-1:0]  load_count_q, load_count_d;
  logic              load_error_q, load_error_d;

`ifdef PROGRAM_LOAD_WATCHDOG_EN
  localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_fired_q, wdog_fired_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      load_count_q <= '0;
      load_error_q <= 1'b0;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
      wdog_cnt_q   <= '0;
      wdog_fired_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      load_count_q <= load_count_d;
      load_error_q <= load_error_d;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_fired_q <= wdog_fired_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_we_d    = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    load_count_d = load_count_q;
    load_error_d = load_error_q;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
    wdog_cnt_d   = wdog_cnt_q;
    wdog_fired_d = wdog_fired_q;
`endif
    unique case (state_q)
      StIdle, StLoad, StDone: begin
        if (uart_valid) begin
          // Entry from IDLE/DONE restarts the load bookkeeping before this word counts.
          if (state_q != StLoad) begin
            load_count_d = '0;
            load_error_d = 1'b0;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
            wdog_fired_d = 1'b0;
`endif
          end
          state_d = StLoad;
          if (uart_data[15:0] == START_MARKER) begin
            state_d = StArm;
          end else if (uart_addr >= MemLimit) begin
            load_error_d = 1'b1;
          end else begin
            pend_we_d   = 1'b1;
            pend_addr_d = uart_addr;
            pend_data_d = uart_data;
            if (load_count_d != {CNT_W{1'b1}}) begin
              load_count_d = load_count_d + 1'b1;
            end
          end
        end
      end
      StArm: begin
        state_d = StRun;
        if (uart_valid) load_error_d = 1'b1;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
        wdog_cnt_d = '0;
`endif
      end
      StRun: begin
        if (uart_valid) load_error_d = 1'b1;
        if (run_finished) begin
          state_d = StDone;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
        end else if (wdog_cnt_q == WdogW'(WDOG_CYCLES - 1)) begin
          state_d      = StDone;
          load_error_d = 1'b1;
          wdog_fired_d = 1'b1;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we     = pend_we_q;
    mem_addr   = pend_we_q ? pend_addr_q : fetch_addr;
    mem_wdata  = pend_data_q;
    run_flag   = (state_q == StRun);
    load_count = load_count_q;
    load_error = load_error_q;
    state      = state_q;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
    wdog_fired = wdog_fired_q;
`endif
  end

endmodule

// File: tb/tb_program_load_sequencer.sv
// Self-checking bench for program_load_sequencer: directed scenarios plus a randomized
// run against a transaction-level model of the boot flow.
module tb_program_load_sequencer;

  localparam int unsigned WDOG = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_valid = 1'b0;
  logic [31:0] uart_data = '0;
  logic [31:0] uart_addr = '0;
  logic [31:0] fetch_addr = '0;
  logic        run_finished = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        run_flag;
  logic [15:0] load_count;
  logic [2:0]  state;
  logic        load_error;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
  logic        wdog_fired;
`endif

  program_load_sequencer #(
    .ADDR_W      (32),
    .MEM_BYTES   (4096),
    .START_MARKER(16'h1111),
    .CNT_W       (16),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_valid  (uart_valid),
    .uart_data   (uart_data),
    .uart_addr   (uart_addr),
    .fetch_addr  (fetch_addr),
    .run_finished(run_finished),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .run_flag    (run_flag),
    .load_count  (load_count),
    .state       (state),
`ifdef PROGRAM_LOAD_WATCHDOG_EN
    .wdog_fired  (wdog_fired),
`endif
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase names map to the published state encoding 0..4.
  int          m_phase;
  int          m_count;
  bit          m_err;
  bit          m_fired;
  int          m_run_cycles;
  bit          m_we;
  logic [31:0] m_waddr;
  logic [31:0] m_wdata;

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_err = 0; m_fired = 0; m_run_cycles = 0; m_we = 0;
    m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    bit wd_en;
`ifdef PROGRAM_LOAD_WATCHDOG_EN
    wd_en = 1;
`else
    wd_en = 0;
`endif
    m_we = 0;
    if (m_phase == 0 || m_phase == 1 || m_phase == 4) begin
      if (uart_valid) begin
        if (m_phase != 1) begin m_count = 0; m_err = 0; m_fired = 0; end
        m_phase = 1;
        if (uart_data[15:0] == 16'h1111) m_phase = 2;
        else if (uart_addr >= 32'd4096) m_err = 1;
        else begin
          m_we = 1; m_waddr = uart_addr; m_wdata = uart_data;
          if (m_count < 65535) m_count++;
        end
      end
    end else if (m_phase == 2) begin
      if (uart_valid) m_err = 1;
      m_phase = 3; m_run_cycles = 0;
    end else begin
      if (uart_valid) m_err = 1;
      m_run_cycles++;
      if (run_finished) m_phase = 4;
      else if (wd_en && m_run_cycles >= WDOG) begin m_phase = 4; m_err = 1; m_fired = 1; end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d);
    uart_valid = v; uart_addr = a; uart_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    uart_valid = 1'b0;
    run_finished = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    fetch_addr = '0;
    do_reset();
    n_cmp++;
    if ({state, run_flag, mem_we, load_error} !== 6'b000_0_0_0) begin
      n_bad++; $display("FAIL reset_flags: got st=%0d rf=%b we=%b err=%b want all 0",
                        state, run_flag, mem_we, load_error);
    end
    n_cmp++;
    if ({load_count, mem_addr, mem_wdata} !== 80'd0) begin
      n_bad++; $display("FAIL reset_data: got cnt=%0d addr=%h wdata=%h want 0",
                        load_count, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_load();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] datas [3] = '{32'h13, 32'h00100093, 32'h00200113};
    for (int i = 0; i < 3; i++) begin
      drive(1, addrs[i], datas[i]);
      step();
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, addrs[i], datas[i]}) begin
        n_bad++; $display("FAIL load_write%0d: got we=%b addr=%h data=%h want 1 %h %h",
                          i, mem_we, mem_addr, mem_wdata, addrs[i], datas[i]);
      end
      step();
      n_cmp++;
      if (mem_we !== 1'b0) begin
        n_bad++; $display("FAIL load_pulse%0d: got we=%b want 0", i, mem_we);
      end
    end
    n_cmp++;
    if ({load_count, state, run_flag} !== {16'd3, 3'd1, 1'b0}) begin
      n_bad++; $display("FAIL load_status: got cnt=%0d st=%0d rf=%b want 3 1 0",
                        load_count, state, run_flag);
    end
  endtask

  task automatic test_marker();
    fetch_addr = 32'h10;
    drive(1, 32'h0, 32'h00001111);
    step();
    n_cmp++;
    if ({state, run_flag, mem_we, mem_addr} !== {3'd2, 1'b0, 1'b0, 32'h10}) begin
      n_bad++; $display("FAIL marker_arm: got st=%0d rf=%b we=%b addr=%h want 2 0 0 10",
                        state, run_flag, mem_we, mem_addr);
    end
    step();
    n_cmp++;
    if ({state, run_flag, mem_addr} !== {3'd3, 1'b1, 32'h10}) begin
      n_bad++; $display("FAIL marker_run: got st=%0d rf=%b addr=%h want 3 1 10",
                        state, run_flag, mem_addr);
    end
  endtask

  task automatic test_finish_reload();
    run_finished = 1'b1;
    step();
    n_cmp++;
    if ({state, run_flag} !== {3'd4, 1'b0}) begin
      n_bad++; $display("FAIL finish_done: got st=%0d rf=%b want 4 0", state, run_flag);
    end
    drive(1, 32'h0, 32'h13);
    step();
    n_cmp++;
    if ({state, load_count, load_error, mem_we} !== {3'd1, 16'd1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reload: got st=%0d cnt=%0d err=%b we=%b want 1 1 0 1",
                        state, load_count, load_error, mem_we);
    end
  endtask

  task automatic test_errors();
    drive(1, 32'h1000, 32'h55);
    step();
    n_cmp++;
    if ({mem_we, load_error, load_count} !== {1'b0, 1'b1, 16'd1}) begin
      n_bad++; $display("FAIL bad_addr: got we=%b err=%b cnt=%0d want 0 1 1",
                        mem_we, load_error, load_count);
    end
    drive(1, 32'h0, 32'hABCD1111);
    step();
    step();
    drive(1, 32'h4, 32'h77);
    step();
    n_cmp++;
    if ({mem_we, load_error, state} !== {1'b0, 1'b1, 3'd3}) begin
      n_bad++; $display("FAIL run_drop: got we=%b err=%b st=%0d want 0 1 3",
                        mem_we, load_error, state);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    drive(1, 32'h20, 32'hABCD);
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_we, state, load_count} !== {1'b0, 3'd0, 16'd0}) begin
      n_bad++; $display("FAIL reset_midload: got we=%b st=%0d cnt=%0d want 0 0 0",
                        mem_we, state, load_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

`ifdef PROGRAM_LOAD_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    drive(1, 32'h0, 32'h13);
    step();
    drive(1, 32'h0, 32'h1111);
    step();
    for (int i = 0; i < int'(WDOG); i++) begin
      step();
      n_cmp++;
      if (state !== 3'd3) begin
        n_bad++; $display("FAIL wdog_run%0d: got st=%0d want 3", i, state);
      end
    end
    step();
    n_cmp++;
    if ({state, wdog_fired, load_error, run_flag} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL wdog_fire: got st=%0d wf=%b err=%b rf=%b want 4 1 1 0",
                        state, wdog_fired, load_error, run_flag);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_addr;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fetch_addr = {$urandom_range(0, 1023), 2'b00};
      uart_valid = ($urandom_range(0, 2) == 0);
      uart_addr = {$urandom_range(0, 1279), 2'b00};
      uart_data = $urandom();
      if ($urandom_range(0, 7) == 0) uart_data[15:0] = 16'h1111;
      run_finished = ($urandom_range(0, 9) == 0);
      step();
      exp_addr = m_we ? m_waddr : fetch_addr;
      n_cmp++;
      if ({state, run_flag, load_error, load_count, mem_we, mem_addr} !==
          {3'(m_phase), (m_phase == 3), m_err, 16'(m_count), m_we, exp_addr}) begin
        n_bad++;
        $display("FAIL rand%0d: got st=%0d rf=%b err=%b cnt=%0d we=%b addr=%h want %0d %b %b %0d %b %h",
                 c, state, run_flag, load_error, load_count, mem_we, mem_addr,
                 m_phase, (m_phase == 3), m_err, m_count, m_we, exp_addr);
      end
      if (m_we) begin
        n_cmp++;
        if (mem_wdata !== m_wdata) begin
          n_bad++; $display("FAIL rand_wdata%0d: got %h want %h", c, mem_wdata, m_wdata);
        end
      end
`ifdef PROGRAM_LOAD_WATCHDOG_EN
      n_cmp++;
      if (wdog_fired !== m_fired) begin
        n_bad++; $display("FAIL rand_wdog%0d: got %b want %b", c, wdog_fired, m_fired);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_marker();
    test_finish_reload();
    test_errors();
    test_reset_mid_load();
`ifdef PROGRAM_LOAD_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
